// File: rtl/dmem_write_buffer_if.sv
// Core-side and data-memory-side signals of the posted-store write buffer.
// slave is the buffer's view; master is the core/memory side that drives it.
interface dmem_write_buffer_if;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic        mem_read;
  logic        mem_write;
  logic        flush;
  logic [31:0] rdata;
  logic        stall;
  logic        busy;
  logic [31:0] dm_addr;
  logic [31:0] dm_data;
  logic        dm_read;
  logic        dm_write;
  logic [31:0] dm_dataout;

  modport slave (
    input  addr, wdata, mem_read, mem_write, flush, dm_dataout,
    output rdata, stall, busy, dm_addr, dm_data, dm_read, dm_write
  );

  modport master (
    output addr, wdata, mem_read, mem_write, flush, dm_dataout,
    input  rdata, stall, busy, dm_addr, dm_data, dm_read, dm_write
  );
endinterface

// File: rtl/dmem_write_buffer.sv
// Posted-store FIFO between the memory stage and data memory; drains in program order.
// Define WBUF_FORWARD_EN to forward load hits from the buffer instead of stalling until drained.
module dmem_write_buffer #(
  parameter int DEPTH        = 4,
  parameter int DRAIN_THRESH = 2
) (
  input  logic               clk,
  input  logic               rst,
  dmem_write_buffer_if.slave bus
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] THRESH = CW'(DRAIN_THRESH);
  localparam logic [CW-1:0] FULL   = CW'(DEPTH);

  logic [31:0]      ent_addr [DEPTH];
  logic [31:0]      ent_data [DEPTH];
  logic [DEPTH-1:0] valid;
  logic [PW-1:0]    head;
  logic [PW-1:0]    tail;
  logic [CW-1:0]    count;

  logic          empty;
  logic          full;
  logic          flushing;
  logic          core_st;
  logic          core_ld;
  logic          idle;
  logic          ld_hit;
  logic          head_hit;
  logic          st_nh_hit;
  logic [PW-1:0] st_idx;
  logic          ld_miss;
  logic          ld_block;
  logic          drain;
  logic          coalesce;
  logic [PW-1:0] co_idx;
  logic          stall_c;
  logic          st_acc;
  logic          push;
`ifdef WBUF_FORWARD_EN
  logic [31:0]   ld_data;
`endif

  assign empty    = (count == '0);
  assign full     = (count == FULL);
  assign flushing = bus.flush && !empty;
  assign core_st  = bus.mem_write && !flushing;
  assign core_ld  = bus.mem_read && !bus.mem_write && !flushing;
  assign idle     = !bus.mem_read && !bus.mem_write;

  // Scan oldest to youngest so the last match recorded is the youngest entry.
  always_comb begin
    ld_hit    = 1'b0;
    st_nh_hit = 1'b0;
    st_idx    = head;
`ifdef WBUF_FORWARD_EN
    ld_data   = '0;
`endif
    for (int i = 0; i < DEPTH; i++) begin
      if (valid[head + PW'(i)] && (ent_addr[head + PW'(i)] == bus.addr)) begin
        ld_hit = 1'b1;
`ifdef WBUF_FORWARD_EN
        ld_data = ent_data[head + PW'(i)];
`endif
        if (i != 0) begin
          st_nh_hit = 1'b1;
          st_idx    = head + PW'(i);
        end
      end
    end
  end

  assign head_hit = valid[head] && (ent_addr[head] == bus.addr);

`ifdef WBUF_FORWARD_EN
  assign ld_block = 1'b0;
`else
  assign ld_block = core_ld && ld_hit;
`endif
  assign ld_miss  = core_ld && !ld_hit;

  // A load miss owns the memory port; otherwise drain on flush, pressure, idle or a blocked load.
  assign drain = !empty && !ld_miss &&
                 (bus.flush || (count >= THRESH) || idle || ld_block);

  // The draining head is leaving, so a store to its address must enqueue behind it.
  assign coalesce = st_nh_hit || (head_hit && !drain);
  assign co_idx   = st_nh_hit ? st_idx : head;

  assign stall_c = flushing || ld_block || (core_st && full && !drain && !coalesce);
  assign st_acc  = core_st && !stall_c;
  assign push    = st_acc && !coalesce;

  assign bus.stall    = stall_c;
  assign bus.busy     = !empty;
  assign bus.dm_read  = ld_miss;
  assign bus.dm_write = drain;
  assign bus.dm_addr  = ld_miss ? bus.addr : (drain ? ent_addr[head] : '0);
  assign bus.dm_data  = drain ? ent_data[head] : '0;

`ifdef WBUF_FORWARD_EN
  assign bus.rdata = core_ld ? (ld_hit ? ld_data : bus.dm_dataout) : '0;
`else
  assign bus.rdata = ld_miss ? bus.dm_dataout : '0;
`endif

  // Control state: pop before push so a full-buffer pop/push on one slot stays valid.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      valid <= '0;
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      if (drain) begin
        valid[head] <= 1'b0;
        head        <= head + PW'(1);
      end
      if (push) begin
        valid[tail] <= 1'b1;
        tail        <= tail + PW'(1);
      end
      count <= count + CW'(push) - CW'(drain);
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      ent_addr[tail] <= bus.addr;
      ent_data[tail] <= bus.wdata;
    end else if (st_acc) begin
      ent_data[co_idx] <= bus.wdata;
    end
  end
endmodule

// File: tb/tb_dmem_write_buffer.sv
// Scoreboard bench for dmem_write_buffer: a queue-based buffer/memory model predicts each
// cycle's outputs; a negedge monitor pops predictions and compares them with the DUT.
`timescale 1ns/1ps
module tb_dmem_write_buffer;
  localparam int DEPTH = 4;
  localparam int TH    = 4;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  dmem_write_buffer_if bus();

  dmem_write_buffer #(.DEPTH(DEPTH), .DRAIN_THRESH(TH)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  function automatic logic [31:0] init_val(input logic [31:0] a);
    return a - 32'd990;
  endfunction

  // Data memory: untouched words read their initial value (mem[1000] = 10).
  logic [31:0]   mem [0:2047];
  logic [2047:0] wflag = '0;
  assign bus.dm_dataout = wflag[bus.dm_addr[10:0]] ? mem[bus.dm_addr[10:0]] : init_val(bus.dm_addr);
  always @(posedge clk) begin
    if (bus.dm_write) begin
      mem[bus.dm_addr[10:0]]   <= bus.dm_data;
      wflag[bus.dm_addr[10:0]] <= 1'b1;
    end
  end

  function automatic logic [31:0] mem_now(input logic [31:0] a);
    return wflag[a[10:0]] ? mem[a[10:0]] : init_val(a);
  endfunction

  typedef struct {
    int          id;
    logic        rd_in;
    logic        wr_in;
    logic        stall;
    logic        busy;
    logic        dm_write;
    logic        dm_read;
    logic [31:0] rdata;
    logic [31:0] dm_addr;
    logic [31:0] dm_data;
  } exp_t;

  typedef struct {
    logic [31:0] a;
    logic [31:0] d;
  } ent_t;

  exp_t        exp_q[$];
  ent_t        q[$];
  logic [31:0] exp_mem [int unsigned];
  int          vectors     = 0;
  int          miscompares = 0;
  int          ncyc        = 0;
  logic        last_stall  = 1'b0;

  function automatic logic [31:0] model_rd(input logic [31:0] a);
    return exp_mem.exists(a) ? exp_mem[a] : init_val(a);
  endfunction

  task automatic chk(input string nm, input int id, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s cycle %0d: got %h, expected %h", nm, id, act, exp);
    end
  endtask

  // One core cycle: drive inputs, predict outputs from the model, advance the model.
  task automatic cyc(input logic r, input logic [31:0] a, input logic [31:0] d,
                     input logic rd, input logic wr, input logic fl);
    exp_t e;
    ent_t ne;
    int   n;
    bit   flushing, st, ld, hit, ldmiss, ldblock, drn, co;
    logic [31:0] hd;
    @(posedge clk);
    #1;
    rst           = r;
    bus.addr      = a;
    bus.wdata     = d;
    bus.mem_read  = rd;
    bus.mem_write = wr;
    bus.flush     = fl;
    e.id    = ncyc;
    e.rd_in = rd;
    e.wr_in = wr;
    ncyc++;
    if (!r) begin
      q.delete();
      e.stall = 0; e.busy = 0; e.dm_write = 0; e.dm_read = 0;
      e.rdata = '0; e.dm_addr = '0; e.dm_data = '0;
    end else begin
      n        = q.size();
      flushing = fl && (n > 0);
      st       = wr && !flushing;
      ld       = rd && !wr && !flushing;
      hit      = 0;
      hd       = '0;
      foreach (q[i]) if (q[i].a == a) begin hit = 1; hd = q[i].d; end
`ifdef WBUF_FORWARD_EN
      ldblock = 0;
`else
      ldblock = ld && hit;
`endif
      ldmiss     = ld && !hit;
      drn        = (n > 0) && !ldmiss && (fl || (n >= TH) || (!rd && !wr) || ldblock);
      e.stall    = flushing || ldblock;
      e.busy     = (n != 0);
      e.dm_write = drn;
      e.dm_read  = ldmiss;
      e.dm_addr  = ldmiss ? a : (drn ? q[0].a : '0);
      e.dm_data  = drn ? q[0].d : '0;
      e.rdata    = (ld && !e.stall) ? (hit ? hd : model_rd(a)) : '0;
      if (drn) begin
        exp_mem[q[0].a] = q[0].d;
        q.delete(0);
      end
      if (st && !e.stall) begin
        co = 0;
        foreach (q[i]) if (q[i].a == a) begin q[i].d = d; co = 1; end
        if (!co) begin
          ne.a = a;
          ne.d = d;
          q.push_back(ne);
        end
      end
    end
    last_stall = e.stall;
    exp_q.push_back(e);
  endtask

  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("stall", e.id, 32'(bus.stall), 32'(e.stall));
        chk("busy", e.id, 32'(bus.busy), 32'(e.busy));
        chk("dm_write", e.id, 32'(bus.dm_write), 32'(e.dm_write));
        chk("dm_read", e.id, 32'(bus.dm_read), 32'(e.dm_read));
        if (e.dm_write || e.dm_read) chk("dm_addr", e.id, bus.dm_addr, e.dm_addr);
        if (e.dm_write) chk("dm_data", e.id, bus.dm_data, e.dm_data);
        if (!(e.rd_in && !e.wr_in && e.stall)) chk("rdata", e.id, bus.rdata, e.rdata);
      end
    end
  end

  initial begin
    logic [31:0] ra, wdv;
    logic        rdv, wrv, flv;
    rst = 1'b0;
    bus.addr = '0; bus.wdata = '0; bus.mem_read = 1'b0; bus.mem_write = 1'b0; bus.flush = 1'b0;

    // Reset held while the core attempts a store.
    cyc(0, 1000, 99, 0, 1, 0);
    cyc(0, 1000, 99, 0, 1, 0);
    cyc(1, 0, 0, 0, 0, 0);
    @(negedge clk);
    chk("mem1000_after_reset", ncyc, mem_now(1000), 32'd10);

    // Forwarding (or blocked load without it).
    cyc(1, 1000, 55, 0, 1, 0);
    cyc(1, 1000, 0, 1, 0, 0);
    cyc(1, 1000, 0, 1, 0, 0);
    cyc(1, 0, 0, 0, 0, 0);

    // Coalescing.
    cyc(1, 1001, 1, 0, 1, 0);
    cyc(1, 1001, 2, 0, 1, 0);
    repeat (2) cyc(1, 0, 0, 0, 0, 0);

    // Full buffer: fifth store drains the head on the same edge.
    for (int i = 0; i < 5; i++) cyc(1, 1002 + i, 100 + i, 0, 1, 0);
    repeat (5) cyc(1, 0, 0, 0, 0, 0);

    // Flush with a store held by the core until the buffer empties.
    for (int i = 0; i < 3; i++) cyc(1, 1007 + i, 7 + i, 0, 1, 0);
    repeat (4) cyc(1, 1012, 12, 0, 1, 1);
    repeat (2) cyc(1, 0, 0, 0, 0, 0);

    // Store then load of the same word.
    cyc(1, 1004, 7, 0, 1, 0);
    cyc(1, 1004, 0, 1, 0, 0);
    cyc(1, 1004, 0, 1, 0, 0);
    cyc(1, 0, 0, 0, 0, 0);

    // Reset mid-run discards buffered stores.
    cyc(1, 1010, 111, 0, 1, 0);
    cyc(1, 1011, 222, 0, 1, 0);
    cyc(0, 0, 0, 0, 0, 0);
    cyc(1, 0, 0, 0, 0, 0);

    // Randomised traffic; a stalled core holds its request.
    ra = 1000; wdv = 0; rdv = 0; wrv = 0; flv = 0;
    for (int k = 0; k < 600; k++) begin
      if (!last_stall) begin
        ra  = 1000 + $urandom_range(0, 7);
        wdv = $urandom;
        rdv = 1'($urandom_range(0, 1));
        wrv = 1'($urandom_range(0, 1));
        flv = ($urandom_range(0, 15) == 0);
      end
      cyc(1, ra, wdv, rdv, wrv, flv);
    end
    repeat (DEPTH + 2) cyc(1, 0, 0, 0, 0, 1);
    cyc(1, 0, 0, 0, 0, 0);

    for (int t = 0; t < 20 && exp_q.size() > 0; t++) @(negedge clk);
    if (exp_q.size() != 0) begin
      miscompares++;
      $display("FAIL monitor_drain: %0d predictions left, expected 0", exp_q.size());
    end
    @(negedge clk);
    for (int a = 1000; a < 1016; a++) chk("final_mem", a, mem_now(32'(a)), model_rd(32'(a)));

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/dmem_write_buffer.md
Name: dmem_write_buffer

Overview:
- Posted-store buffer between the single-cycle datapath's memory stage and the word-addressed data memory.
- Stores retire into a small FIFO in one cycle and drain to memory in program order on otherwise-free memory-port cycles.
- Loads check the buffer first (youngest match wins); a miss reads memory combinationally.
- Flush input forces a full drain (used before halt and before the bench inspects memory).

Parameters:
- DEPTH, 4, number of buffer entries; power of two, 2..16.
- DRAIN_THRESH, 2, occupancy at or above which the buffer drains even while the core uses the memory port for stores; range 1..DEPTH.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  asynchronous reset, active-low (0 = reset).
- addr  in  32  core word address.
- wdata  in  32  core store data.
- mem_read  in  1  core load request.
- mem_write  in  1  core store request.
- flush  in  1  level request to empty the buffer.
- rdata  out  32  load data; 0 when mem_read=0.
- stall  out  1  core must hold its current access; asserted in the same cycle as the condition.
- busy  out  1  buffer non-empty.
- dm_addr  out  32  data-memory address.
- dm_data  out  32  data-memory write data.
- dm_read  out  1  data-memory read enable.
- dm_write  out  1  data-memory write enable, one cycle per drained entry.
- dm_dataout  in  32  data-memory read data (combinational).

Behaviour:
- Reset (rst=0, any time): all valid bits, head/tail pointers and count go to 0. stall=0, busy=0, dm_write=0, dm_read=0. Buffered stores are discarded and never written.
- State: a circular FIFO of {addr, data, valid} plus a count of width clog2(DEPTH)+1. Pointers wrap modulo DEPTH.
- Drain decision (combinational, at most one entry per cycle): drain=1 when count>0 and no load miss is using the port this cycle, and any of: flush=1; count>=DRAIN_THRESH; mem_read=0 and mem_write=0 (idle cycle).
- When drain=1: dm_write=1, dm_addr=head.addr, dm_data=head.data; head is popped at the clock edge. When drain=0: dm_write=0.
- Store (mem_write=1, stall=0): accepted at the clock edge with zero-cycle latency.
  - Coalescing: if a valid entry other than the draining head has the same addr, its data is overwritten and count is unchanged.
  - Otherwise the store is enqueued at tail.
  - If the buffer is full, the store is accepted only together with a drain in the same cycle; drain is forced because count>=DRAIN_THRESH. The pop and push happen on the same edge, count stays at DEPTH, and stall=0.
- Load (mem_read=1):
  - Hit: the search runs youngest to oldest. rdata = the matching entry's data, dm_read=0, and a drain may proceed.
  - Miss: dm_read=1, dm_addr=addr, rdata=dm_dataout, dm_write=0, and no drain this cycle.
- mem_read and mem_write both high: treated as a store only; rdata=0.
- Flush: while flush=1 and count>0, stall=1, core requests are ignored, and one entry drains per cycle. stall falls combinationally in the cycle count reaches 0. Flush with an empty buffer gives stall=0.
- Ordering: memory sees writes in program order. Two entries for the same addr can exist only transiently, when a store hits the head as it drains; the head writes first.
- busy = (count != 0).

Optional Feature:
- Macro: WBUF_FORWARD_EN.
- Defined: load hits are forwarded from the buffer as described above.
- Undefined: there is no forwarding. A load whose addr matches any valid entry asserts stall and forces drain each cycle until no entry matches. The load then completes from memory.

Test Plan:
- Reset: hold rst=0 with mem_write=1 -> busy=0, dm_write=0, stall=0; after release, mem[1000] is unchanged (10).
- Forwarding: DRAIN_THRESH=4. Store 1000<-55, then load 1000 next cycle -> rdata=55, dm_read=0. Idle cycle -> dm_write=1, dm_addr=1000, dm_data=55.
- Coalesce: DRAIN_THRESH=4. Store 1001<-1, then store 1001<-2 -> count=1. Idle -> exactly one dm_write, mem[1001]=2.
- Full: DRAIN_THRESH=DEPTH=4. Stores to 1002..1005, then a 5th store to 1006 -> same cycle dm_write to 1002, stall=0, count stays 4.
- Flush: 3 entries (1007..1009 <- 7,8,9), flush=1 -> stall high 3 cycles, dm_write in order 1007, 1008, 1009, then stall=0 and busy=0.
- WBUF_FORWARD_EN undefined: store 1004<-7, load 1004 -> stall=1 for one cycle while 1004 drains, then rdata=7 via dm_read=1.
